// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-FF input synchronizer, mid-bit sampling off a limit counter,
// LSB-first byte assembly and software-cleared sticky status flags.
module uart_rx #(
  parameter int CLKS_PER_BIT = 5208,
  parameter int CNT_W        = $clog2(CLKS_PER_BIT)
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  input  logic       clear,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_ready,
  output logic       overrun,
  output logic       frame_err,
  output logic       busy
);

  localparam int               HALF    = CLKS_PER_BIT / 2;
  localparam logic [CNT_W-1:0] LAST    = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(HALF - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_WAIT_HI
  } state_t;

  state_t           r_state;
  logic             r_sync1;
  logic             r_sync2;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_idx;
  logic [7:0]       r_shift;
  logic [7:0]       r_data;
  logic             r_valid;
  logic             r_ready;
  logic             r_overrun;
  logic             r_ferr;
  logic             r_busy;

  assign rx_data   = r_data;
  assign rx_valid  = r_valid;
  assign rx_ready  = r_ready;
  assign overrun   = r_overrun;
  assign frame_err = r_ferr;
  assign busy      = r_busy;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_sync1   <= 1'b1;
      r_sync2   <= 1'b1;
      r_cnt     <= '0;
      r_idx     <= '0;
      r_shift   <= '0;
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_ready   <= 1'b0;
      r_overrun <= 1'b0;
      r_ferr    <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_sync1 <= rx;
      r_sync2 <= r_sync1;
      r_valid <= 1'b0;

      // clear is applied first so a completion event later in this block wins
      if (clear) begin
        r_ready   <= 1'b0;
        r_overrun <= 1'b0;
        r_ferr    <= 1'b0;
      end

      case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
          if (!r_sync2) begin
            r_state <= S_START;
            r_busy  <= 1'b1;
          end
        end

        S_START: begin
          if (r_cnt == HALF_M1) begin
            r_cnt <= '0;
            if (!r_sync2) begin
              r_state <= S_DATA;
              r_idx   <= '0;
            end else begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        S_DATA: begin
          if (r_cnt == LAST) begin
            r_cnt          <= '0;
            r_shift[r_idx] <= r_sync2;
            r_idx          <= r_idx + 3'd1;
            if (r_idx == 3'd7) r_state <= S_STOP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        S_STOP: begin
          if (r_cnt == LAST) begin
            r_cnt <= '0;
            if (r_sync2) begin
              r_data    <= r_shift;
              r_valid   <= 1'b1;
              r_ready   <= 1'b1;
              r_overrun <= !clear && (r_overrun || r_ready);
              r_state   <= S_IDLE;
              r_busy    <= 1'b0;
            end else begin
              r_ferr  <= 1'b1;
              r_state <= S_WAIT_HI;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        S_WAIT_HI: begin
          r_cnt <= '0;
          if (r_sync2) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        end

        default: begin
          r_state <= S_IDLE;
          r_cnt   <= '0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial receive side of the processor's UART peripheral. Oversamples an asynchronous 8N1 line with an internal bit-period counter, reassembles bytes LSB-first, and presents them to the memory-mapped peripheral interface. Status is held in flags that software clears. It is the counterpart of the transmit path, which drives the line using the same limit-counter bit timing.

## Interface
- `CLKS_PER_BIT`, default 5208: clock cycles per serial bit. Minimum 4. `HALF = CLKS_PER_BIT/2`, using floor.
- `CNT_W`, default `$clog2(CLKS_PER_BIT)`: width of the bit-period counter.

- `clk` in 1: single system clock, rising edge.
- `rst_n` in 1: reset. Synchronous, active-low.
- `rx` in 1: asynchronous serial line. Idle level is 1.
- `clear` in 1: clears `rx_ready`, `overrun` and `frame_err`.
- `rx_data` out 8: last correctly framed byte.
- `rx_valid` out 1: one-cycle pulse when a new byte is written to `rx_data`.
- `rx_ready` out 1: sticky flag. Set on a good byte, cleared by `clear`.
- `overrun` out 1: sticky flag. Set when a byte completes while `rx_ready` is still set.
- `frame_err` out 1: sticky flag. Set when the stop bit is sampled as 0.
- `busy` out 1: high whenever the FSM is not in IDLE.

## Operation
- Input synchronizer:
  - `rx` passes through a 2-FF synchronizer, giving `rx_s`.
  - Both FFs reset to 1.
- Bit counter `cnt`:
  - Counts up from 0.
  - Is reset to 0 on every state change.
  - Never exceeds `CLKS_PER_BIT-1`.
- FSM states: IDLE, START, DATA, STOP, WAIT_HI.
  - IDLE: when `rx_s==0`, go to START.
  - START: at `cnt==HALF-1`, sample `rx_s`.
    - If 0: go to DATA with bit index 0.
    - If 1 (glitch): go back to IDLE.
  - DATA: at `cnt==CLKS_PER_BIT-1`, shift `rx_s` into bit `idx` of the shift register, LSB first.
    - After bit 7, go to STOP.
  - STOP: at `cnt==CLKS_PER_BIT-1`, sample `rx_s`.
    - If 1: load `rx_data` from the shift register, pulse `rx_valid`, set `rx_ready`, go to IDLE.
    - If 0: set `frame_err`. `rx_data` and `rx_ready` are unchanged. Go to WAIT_HI.
  - WAIT_HI: go to IDLE only after `rx_s==1`. A held-low line (break) produces no repeated frames.
- Overrun:
  - If `rx_ready==1` and `clear==0` on the cycle a good stop is sampled, set `overrun`.
  - `rx_data` is still overwritten with the new byte.
- `clear` and a completion event in the same cycle:
  - The completion wins: `rx_ready` ends at 1, `frame_err` is set if the stop was bad, and `overrun` is not set.
  - Flags not affected by the event are cleared.
- `clear` does not disturb the FSM, the shift register or `rx_data`.

## Timing
- Reset (`rst_n==0` at a rising edge) produces the following, regardless of state, including mid-frame:
  - `rx_data=8'h00`.
  - `rx_valid`, `rx_ready`, `overrun`, `frame_err` and `busy` are 0.
  - FSM in IDLE, `cnt=0`, `idx=0`, shift register 0, synchronizer FFs 1.
- Let E0 be the first edge at which `rx==0` is captured by sync FF1.
  - `rx_s==0` is seen by the FSM at E2 = E0+2, which enters START.
  - Start check at edge E2+HALF.
  - Data bit i sampled at edge E2+HALF+(i+1)·CLKS_PER_BIT, for i = 0..7.
  - Stop bit sampled at edge E2+HALF+9·CLKS_PER_BIT.
  - `rx_valid`, `rx_ready` and `rx_data` update on that same edge, so they are visible in the following cycle. `rx_valid` is high for exactly 1 cycle.
- The FSM is back in IDLE at mid-stop-bit, so a start bit immediately after the stop bit (zero idle gap) is received correctly.
- Outputs are registered. There is no combinational path from `rx` or `clear` to any output.
- Sampling tolerance: a glitch shorter than HALF cycles at the start bit is rejected.

## Test plan
1. `CLKS_PER_BIT=16`. Drive frame 0xA5 (start, 1,0,1,0,0,1,0,1 LSB-first, stop).
   - Required: `rx_valid` high for exactly 1 cycle, at edge E0+2+8+144.
   - Then `rx_data=8'hA5`, `rx_ready=1`, `busy=0`, `frame_err=0`.
2. Glitch: `rx` low for 4 cycles, then high.
   - Required: `busy` high, then back to 0 at E0+2+8. No `rx_valid`, all flags 0.
3. Framing error: frame 0x3C with a 0 stop bit, line held low for a further 100 cycles, then high.
   - Required: `frame_err=1`, `rx_ready=0`, `rx_data` unchanged.
   - FSM stays in WAIT_HI (`busy=1`) until the line rises. No second frame is received.
4. Overrun: send 0x11 then 0x22 with no `clear`.
   - Required: `overrun=1`, `rx_data=8'h22`, `rx_ready=1`.
   - Asserting `clear` for 1 cycle makes all three flags 0.
   - `clear` asserted on the exact completion edge of a third byte gives `rx_ready=1` and `overrun=0`.
5. Back-to-back: 0x00 immediately followed by 0xFF, with no idle gap.
   - Required: two `rx_valid` pulses, exactly 10·CLKS_PER_BIT cycles apart, with data 0x00 then 0xFF.
6. Reset mid-frame: assert `rst_n=0` for 1 cycle during DATA bit 3 of 0x5A, then send a clean 0xC3.
   - Required: all outputs 0 after the reset edge. No partial byte is delivered. Then `rx_data=8'hC3` with a single `rx_valid` pulse.
